pattern_collector: RTL

PATTERN_COLLECTOR -- requirements
Module: pattern_collector

---
 rtl/pattern_collector.sv | 114 +++++++++++
 1 files changed

// File: rtl/pattern_collector.sv
// pattern_collector: collects a round of one-hot key presses as 2-bit colors packed LSB-first.
// Define SIMON_INPUT_TIMEOUT_EN to abort a round after TIMEOUT_CYCLES idle cycles in WAIT_PRESS.
module pattern_collector #(
  parameter int MAX_COLORS     = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              length,
  input  logic [3:0]              keys,
  output logic [2*MAX_COLORS-1:0] pattern,
  output logic [1:0]              color,
  output logic                    color_valid,
  output logic [3:0]              count,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout
);
  localparam int PW = 2*MAX_COLORS;
  localparam logic [3:0] MAXC = 4'(MAX_COLORS);
  if (MAX_COLORS < 1 || MAX_COLORS > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("pattern_collector: unsupported MAX_COLORS or TIMEOUT_CYCLES");
  end
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;
  state_t        state_q;
  logic [PW-1:0] pattern_q;
  logic [1:0]    color_q;
  logic [3:0]    count_q, len_q, len_d;
  logic          cv_q, busy_q, done_q, timeout_q;
  logic          one_hot;
  logic [1:0]    key_idx;
  logic [PW-1:0] slot;
`ifdef SIMON_INPUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;
`endif
  always_comb begin
    len_d   = length == 4'd0 ? 4'd1 : (length > MAXC ? MAXC : length);
    one_hot = keys != 4'd0 && (keys & (keys - 4'd1)) == 4'd0;
    key_idx = keys[3] ? 2'd3 : keys[2] ? 2'd2 : keys[1] ? 2'd1 : 2'd0;
    // slots beyond count are still zero after start, so OR-ing in the new color is a write
    slot    = PW'(key_idx) << {count_q, 1'b0};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      color_q   <= '0;
      count_q   <= '0;
      len_q     <= '0;
      cv_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef SIMON_INPUT_TIMEOUT_EN
      tcnt_q    <= '0;
`endif
    end else begin
      cv_q      <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      if (start) begin
        state_q   <= WAIT_PRESS;
        busy_q    <= 1'b1;
        pattern_q <= '0;
        count_q   <= '0;
        len_q     <= len_d;
`ifdef SIMON_INPUT_TIMEOUT_EN
        tcnt_q    <= '0;
`endif
      end else begin
        case (state_q)
          WAIT_PRESS:
            if (one_hot) begin
              state_q   <= WAIT_RELEASE;
              pattern_q <= pattern_q | slot;
              color_q   <= key_idx;
              count_q   <= count_q + 4'd1;
              cv_q      <= 1'b1;
`ifdef SIMON_INPUT_TIMEOUT_EN
              tcnt_q    <= '0;
            end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              timeout_q <= 1'b1;
              tcnt_q    <= '0;
            end else begin
              tcnt_q    <= tcnt_q + TW'(1);
`endif
            end
          WAIT_RELEASE:
            if (keys == 4'd0) begin
              state_q <= count_q == len_q ? DONE : WAIT_PRESS;
              busy_q  <= count_q != len_q;
              done_q  <= count_q == len_q;
            end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  assign pattern     = pattern_q;
  assign color       = color_q;
  assign color_valid = cv_q;
  assign count       = count_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef SIMON_INPUT_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif
endmodule
